// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: command bytes, FSM states
// and the frame parity helper.
package ps2_host_tx_pkg;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_XFER,
    ST_ACK,
    ST_WAIT_IDLE
  } state_e;

  // PS/2 frames carry odd parity: data bits plus parity bit hold an odd count of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Two-flop synchroniser plus glitch filter for one PS/2 pad; a new level is
// accepted only after FILTER_LEN consecutive equal samples, with a fall strobe.
module ps2_host_tx_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_in,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_LEN) + 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    level_d = level_q;
    cnt_d   = '0;
    fall_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync2_q;
        fall_d  = level_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Idle bus is pulled up, so the chain resets to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= pad_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits LSB
// first, odd parity, stop, then device ACK check, with an inter-edge timeout.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned INHIBIT_CYC = (CLK_HZ / 1_000_000) * 120,
  parameter int unsigned TIMEOUT_CYC = (CLK_HZ / 1_000) * 20,
  parameter int unsigned FILTER_LEN  = 8
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  logic clk_lvl, clk_fall, data_lvl, unused_data_fall;

  ps2_host_tx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk    (CLK),
    .rst_n  (rst),
    .pad_in (ps2_clk_in),
    .level  (clk_lvl),
    .fall   (clk_fall)
  );

  ps2_host_tx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk    (CLK),
    .rst_n  (rst),
    .pad_in (ps2_data_in),
    .level  (data_lvl),
    .fall   (unused_data_fall)
  );

  state_e           state_q, state_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             timeout, abort;

  assign timeout = (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    abort     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d = {1'b1, odd_parity(tx_data), tx_data};
          idx_d   = '0;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = ST_RTS;
        end
      end
      ST_RTS: begin
        cnt_d   = '0;
        state_d = ST_XFER;
      end
      // Start bit stays on the line until the first device fall; then one bit per fall.
      ST_XFER: begin
        cnt_d = cnt_q + 1'b1;
        if (clk_fall) begin
          cnt_d     = '0;
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          idx_d     = idx_q + 4'd1;
          if (idx_q == 4'd9) state_d = ST_ACK;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      ST_ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (clk_fall) begin
          cnt_d = '0;
          if (!data_lvl) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = cnt_q + 1'b1;
        if (clk_lvl && data_lvl) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      cnt_d     = '0;
      data_oe_d = 1'b0;
      err_d     = 1'b1;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2_clk_oe  = (state_q == ST_INHIBIT) || (state_q == ST_RTS);
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: models an open-drain PS/2 keyboard that clocks the
// host frame in, and checks captured frames against a byte-level frame model.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int unsigned INH  = 100;
  localparam int unsigned TO   = 400;
  localparam int unsigned FL   = 8;
  localparam int          HALF = 40;

  logic       CLK, rst, tx_valid, tx_ready, ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, err;
  logic [7:0] tx_data;

  logic dev_clk, dev_data, glitch;
  logic clk_line, data_line;
  assign clk_line    = dev_clk & ~ps2_clk_oe;
  assign data_line   = dev_data & ~ps2_data_oe;
  assign ps2_clk_in  = clk_line & ~glitch;
  assign ps2_data_in = data_line;

  int total = 0, bad = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0;
  bit scramble_en = 0, glitch_en = 0, drop_valid = 0;
  logic [7:0] next_byte;

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO), .FILTER_LEN(FL)) dut (
    .CLK         (CLK),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    #1;
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    if (done === 1'b1 && err === 1'b1) both_cnt++;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) acc_cnt++;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: time=%0t limit reached", $time);
    $fatal(1, "bench stuck");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference frame as the device sees it: {stop, parity, data, start}.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 5000) begin @(negedge CLK); n++; end
  endtask

  task automatic wait_result(input int d0, input int e0, input string tag);
    int n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 600) begin @(negedge CLK); n++; end
    check({tag, "_result_seen"}, 32'(n < 600), 32'd1);
    repeat (3) @(negedge CLK);
  endtask

  // Device model: waits for inhibit/RTS, clocks 11 falls, captures start..stop, optional ACK.
  task automatic dev_xfer(input bit give_ack, input int abort_fall,
                          output logic [10:0] cap, output int inh, output bit ok);
    int n = 0;
    ok  = 1'b1;
    cap = '0;
    inh = 0;
    while (clk_line !== 1'b0 && n < 2000) begin @(negedge CLK); n++; end
    if (n >= 2000) begin ok = 1'b0; return; end
    if (drop_valid) tx_valid = 1'b0;
    n = 0;
    while (data_line !== 1'b0 && n < 4 * int'(INH)) begin @(negedge CLK); inh++; n++; end
    n = 0;
    while (clk_line !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    if (n >= 20) begin ok = 1'b0; return; end
    cap[0] = data_line;
    for (int f = 1; f <= 11; f++) begin
      for (int c = 0; c < HALF; c++) begin
        if (glitch_en && c == 10) glitch = 1'b1;
        if (glitch_en && c == 12) glitch = 1'b0;
        if (f == 11 && give_ack && c == HALF / 2) dev_data = 1'b0;
        @(negedge CLK);
      end
      dev_clk = 1'b0;
      if (f == abort_fall) begin
        repeat (20) @(negedge CLK);
        return;
      end
      repeat (HALF - 1) @(negedge CLK);
      if (f <= 10) cap[f] = data_line;
      @(negedge CLK);
      dev_clk = 1'b1;
      if (scramble_en) tx_data = (f >= 10) ? next_byte : 8'($urandom);
    end
    repeat (HALF / 2) @(negedge CLK);
    dev_data = 1'b1;
  endtask

  task automatic do_xfer(input logic [7:0] b, input bit ack, input string tag,
                         output int inh, output logic [10:0] cap);
    bit ok;
    int d0, e0;
    wait_idle();
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge CLK);
    tx_valid = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    dev_xfer(ack, 0, cap, inh, ok);
    check({tag, "_dev_ok"}, 32'(ok), 32'd1);
    check({tag, "_frame"}, 32'(cap), 32'(frame_of(b)));
    wait_result(d0, e0, tag);
    check({tag, "_done"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
    check({tag, "_err"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
    check({tag, "_idle"}, {29'd0, busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
  endtask

  initial begin
    int inh, n, d0, e0, a0;
    bit ok;
    logic [10:0] cap;
    logic [7:0] a, b;

    rst = 1'b0; tx_valid = 1'b0; tx_data = '0;
    dev_clk = 1'b1; dev_data = 1'b1; glitch = 1'b0; next_byte = '0;
    repeat (3) @(negedge CLK);
    check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("rst_flags", {29'd0, busy, done, err}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge CLK);
    check("post_rst_ready", {31'd0, tx_ready}, 32'd1);

    // Set-LED command with explicit expected bit pattern and inhibit length.
    do_xfer(CMD_SET_LED, 1'b1, "ed", inh, cap);
    check("ed_bits", 32'(cap), 32'b1_1_11101101_0);
    check("ed_inhibit", (inh >= int'(INH)) ? INH : 32'(inh), INH);

    do_xfer(8'h00, 1'b1, "b00", inh, cap);
    check("b00_parity", {31'd0, cap[9]}, 32'd1);
    do_xfer(8'h01, 1'b1, "b01", inh, cap);
    check("b01_parity", {31'd0, cap[9]}, 32'd0);

    // Device withholds ACK.
    do_xfer(8'($urandom), 1'b0, "nack", inh, cap);

    // Device never clocks after RTS.
    wait_idle();
    d0 = done_cnt; e0 = err_cnt;
    tx_data = 8'($urandom); tx_valid = 1'b1;
    @(negedge CLK);
    tx_valid = 1'b0;
    n = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < int'(INH) + 20) begin
      @(negedge CLK); n++;
    end
    check("to_reach_xfer", 32'(n < int'(INH) + 20), 32'd1);
    n = 0;
    while (err !== 1'b1 && n < int'(TO) + 20) begin @(negedge CLK); n++; end
    check("to_cycles", (n >= int'(TO) - 1 && n <= int'(TO) + 1) ? TO : 32'(n), TO);
    check("to_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("to_ready", {31'd0, tx_ready}, 32'd1);
    repeat (3) @(negedge CLK);
    check("to_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("to_done_cnt", 32'(done_cnt - d0), 32'd0);

    // Reset after fall 5 while D4 (0 in 0xA5) is being driven low.
    wait_idle();
    d0 = done_cnt; e0 = err_cnt;
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge CLK);
    tx_valid = 1'b0;
    dev_xfer(1'b1, 5, cap, inh, ok);
    check("mid_rst_drive", {31'd0, ps2_data_oe}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    dev_clk = 1'b1; dev_data = 1'b1;
    repeat (5) @(negedge CLK);
    check("mid_rst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge CLK);
    do_xfer(CMD_RESET, 1'b1, "after_rst", inh, cap);

    // tx_valid held with changing data plus clock glitches: one byte per handshake.
    wait_idle();
    a = 8'($urandom); b = 8'($urandom);
    d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
    next_byte = b; scramble_en = 1'b1; glitch_en = 1'b1;
    tx_data = a; tx_valid = 1'b1;
    dev_xfer(1'b1, 0, cap, inh, ok);
    scramble_en = 1'b0; glitch_en = 1'b0;
    check("hold_first_frame", 32'(cap), 32'(frame_of(a)));
    wait_result(d0, e0, "hold_first");
    check("hold_first_done", 32'(done_cnt - d0), 32'd1);
    drop_valid = 1'b1;
    dev_xfer(1'b1, 0, cap, inh, ok);
    drop_valid = 1'b0;
    check("hold_second_ok", 32'(ok), 32'd1);
    check("hold_second_frame", 32'(cap), 32'(frame_of(b)));
    wait_result(d0 + 1, e0, "hold_second");
    check("hold_done_total", 32'(done_cnt - d0), 32'd2);
    check("hold_err_total", 32'(err_cnt - e0), 32'd0);
    check("hold_accepts", 32'(acc_cnt - a0), 32'd2);

    // Randomized traffic, mixing in named command bytes.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] rb;
      bit rack;
      rb   = (i == 0) ? CMD_ENABLE : (i == 1) ? RSP_ACK : 8'($urandom);
      rack = ($urandom_range(0, 3) != 0);
      do_xfer(rb, rack, $sformatf("rnd%0d", i), inh, cap);
    end

    check("never_done_and_err", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
